uart_rx_arbiter: RTL and testbench
==================================

Name: uart_rx_arbiter

Overview:
- Collects received bytes from NCH independent uart_rx instances and merges them into one byte stream tagged with the channel number.
- Each channel has a one-deep holding register. Channels are serviced round-robin, and the output uses a valid/ready handshake.
- Sits between the logger's sensor UART receivers and the shared packet/storage path. Reports per-channel overrun status.

Parameters:
- NCH, 4, number of UART receive channels (legal 2..8).
- CW, 2, channel-index width; must equal clog2(NCH), minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_done  in  NCH  per-channel one-cycle byte-received pulse (bit i = channel i).
- rx_byte  in  8*NCH  per-channel data; bits [8i+7:8i] belong to channel i; valid in the cycle rx_done[i] is high.
- chan_en  in  NCH  per-channel capture enable; 0 = ignore rx_done on that channel.
- out_ready  in  1  downstream accepts the presented byte.
- out_valid  out  1  byte presented.
- out_byte  out  8  presented data.
- out_chan  out  CW  channel index of out_byte.
- ovr_flags  out  NCH  sticky overrun flag per channel.
- ovr_clr  in  NCH  write-1-to-clear for ovr_flags, one bit per channel.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid=0, out_byte=0, out_chan=0, ovr_flags=0.
  - All hold_valid=0, round-robin pointer=0, FSM=IDLE.
- Capture, per channel i:
  - If rx_done[i]=1, chan_en[i]=1 and hold_valid[i]=0: hold_byte[i]<=rx_byte[i] and hold_valid[i]<=1 on the next edge.
  - If hold_valid[i]=1 and the same channel is not being consumed this cycle: the new byte is dropped, the held byte is unchanged, and ovr_flags[i]<=1.
  - If a capture and a consume of channel i happen in the same cycle: the new byte is stored, hold_valid[i] stays 1, and no overrun is flagged.
  - Clearing chan_en[i] does not discard a byte already held; that byte is still serviced.
- Overrun flags:
  - ovr_clr[i] clears ovr_flags[i] on the next edge.
  - If a set and a clear coincide, set wins.
- FSM state IDLE:
  - Search hold_valid starting at the pointer index and wrapping modulo NCH. The first set bit is the grant g.
  - If a grant is found: out_byte<=hold_byte[g], out_chan<=g, out_valid<=1, go to PRESENT.
  - If no bit is set, stay in IDLE.
- FSM state PRESENT:
  - out_valid=1. out_byte and out_chan are held stable until the transfer.
  - Transfer occurs when out_valid=1 and out_ready=1. On that edge:
    - hold_valid[g] is cleared, unless a same-cycle capture on g applies.
    - pointer<=(g+1) mod NCH.
    - out_valid<=0, FSM<=IDLE.
  - out_ready while out_valid=0 has no effect.
- Latency:
  - rx_done at edge t → hold_valid at t+1 → out_valid at t+2 when IDLE and the channel wins arbitration.
  - Minimum spacing between consecutive transfers is 2 cycles (one IDLE cycle between presentations).
- Fairness: a channel holding a byte is presented within NCH presentations.
- Widths and indices:
  - The pointer is CW bits and wraps from NCH-1 to 0.
  - Indices >= NCH are never produced when NCH is not a power of two.
- Reset mid-presentation: out_valid drops immediately (asynchronously), held data is discarded, and the pointer returns to 0.

Test Plan:
1. Single byte: rx_done[2] with 0xA5, out_ready=1 → out_valid high exactly 2 cycles later with out_byte=0xA5 and out_chan=2; one transfer; ovr_flags=0.
2. Simultaneous arrival: rx_done=4'b1111 with bytes 0x10,0x11,0x12,0x13, out_ready=1 → outputs on channels 0,1,2,3 in order, each separated by one idle cycle. A second burst on channels 0 and 3 then yields 0 before 3 (pointer=0 after wrap).
3. Backpressure overrun: out_ready=0, channel 1 receives 0x55 then 0x66 → presentation stays 0x55 and ovr_flags[1]=1. Raise out_ready → 0x55 transferred, 0x66 never appears. Pulse ovr_clr[1] → flag returns to 0.
4. Consume/capture collision: channel 0 presented with 0x01; rx_done[0] with 0x02 in the same cycle as out_ready=1 → 0x02 presented next with no overrun.
5. Enable mask: chan_en=4'b1101, rx_done[1] with 0x77 → nothing captured and no overrun. Re-enable channel 1 and send 0x78 → 0x78 output on channel 1.
6. Reset mid-operation: assert reset_n=0 while out_valid=1 with bytes held on 3 channels → out_valid=0 immediately, no stale byte after release, and the first new byte on channel 3 is output with out_chan=3.

Source files
------------

// File: rtl/uart_rx_arbiter.sv
// uart_rx_arbiter: merges bytes from NCH UART receivers into one channel-tagged valid/ready stream
//   clk, reset_n        : clock, asynchronous active-low reset
//   rx_done/rx_byte     : per-channel byte-received pulse and data (channel i at [8i+7:8i])
//   chan_en             : per-channel capture enable
//   out_valid/out_ready : output handshake; out_byte/out_chan carry the byte and its channel
//   ovr_flags/ovr_clr   : sticky per-channel overrun flags and their write-1-to-clear
module uart_rx_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   rx_done,
  input  logic [8*NCH-1:0] rx_byte,
  input  logic [NCH-1:0]   chan_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic [CW-1:0]    out_chan,
  output logic [NCH-1:0]   ovr_flags,
  input  logic [NCH-1:0]   ovr_clr
);
  typedef enum logic {IDLE, PRESENT} state_e;
  state_e         state_q;
  logic [NCH-1:0] hv_q, hv_d, ovr_q, ovr_d, cons;
  logic [7:0]     hb_q [NCH];
  logic [7:0]     hb_d [NCH];
  logic [CW-1:0]  ptr_q, g, out_chan_q;
  logic [7:0]     out_byte_q;
  logic           out_valid_q, found, xfer;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_chan  = out_chan_q;
  assign ovr_flags = ovr_q;
  always_comb begin
    xfer  = state_q == PRESENT && out_ready;
    cons  = xfer ? NCH'(1) << out_chan_q : '0;
    hv_d  = hv_q;
    hb_d  = hb_q;
    ovr_d = ovr_q & ~ovr_clr;
    for (int i = 0; i < NCH; i++) begin
      // a byte arriving while its channel is being consumed refills the slot instead of overrunning
      if (rx_done[i] && chan_en[i] && (!hv_q[i] || cons[i])) begin
        hb_d[i] = rx_byte[8*i +: 8];
        hv_d[i] = 1'b1;
      end else begin
        if (cons[i]) hv_d[i] = 1'b0;
        if (rx_done[i] && chan_en[i] && hv_q[i]) ovr_d[i] = 1'b1;
      end
    end
    found = 1'b0;
    g     = '0;
    for (int k = 0; k < NCH; k++)
      if (!found && hv_q[(int'(ptr_q) + k) % NCH]) begin
        found = 1'b1;
        g     = CW'((int'(ptr_q) + k) % NCH);
      end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hv_q        <= '0;
      hb_q        <= '{default: '0};
      ovr_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      hv_q  <= hv_d;
      hb_q  <= hb_d;
      ovr_q <= ovr_d;
      if (state_q == IDLE) begin
        if (found) begin
          out_byte_q  <= hb_q[g];
          out_chan_q  <= g;
          out_valid_q <= 1'b1;
          state_q     <= PRESENT;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        ptr_q       <= out_chan_q == CW'(NCH-1) ? '0 : out_chan_q + 1'b1;
        state_q     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb_uart_rx_arbiter: vector table, directed corner cases and randomized model check of uart_rx_arbiter
module tb_uart_rx_arbiter;
  localparam int NCH = 4;
  localparam int CW  = 2;
  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NCH-1:0]   rx_done = '0;
  logic [8*NCH-1:0] rx_byte = '0;
  logic [NCH-1:0]   chan_en = '1;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic [CW-1:0]    out_chan;
  logic [NCH-1:0]   ovr_flags;
  logic [NCH-1:0]   ovr_clr = '0;
  int total = 0;
  int bad = 0;
  uart_rx_arbiter #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_byte(rx_byte),
    .chan_en(chan_en), .out_ready(out_ready), .out_valid(out_valid),
    .out_byte(out_byte), .out_chan(out_chan), .ovr_flags(ovr_flags), .ovr_clr(ovr_clr)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  done;
    logic [31:0] bytes;
    logic [3:0]  en;
    logic        rdy;
    logic [3:0]  clr;
    logic        ev;
    logic [7:0]  eb;
    logic [1:0]  ec;
    logic [3:0]  eo;
  } vec_t;
  vec_t tv [15];
  bit         m_held [NCH];
  logic [7:0] m_val [NCH];
  logic [3:0] m_ovr;
  int         m_ptr, m_pres;
  logic [7:0] m_pbyte;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    rx_done = '0;
    rx_byte = '0;
    chan_en = '1;
    out_ready = 1'b0;
    ovr_clr = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic send(input logic [3:0] d, input logic [31:0] b);
    rx_done = d;
    rx_byte = b;
    step();
    rx_done = '0;
  endtask
  task automatic expect_pres(input string nm, input int ch, input logic [7:0] b, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_chan"}, 32'(out_chan), 32'(ch));
    chk({nm, "_byte"}, 32'(out_byte), 32'(b));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tv[0]  = '{4'b0100, 32'h00A50000, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[1]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b1, 8'hA5, 2'd2, 4'h0};
    tv[2]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[3]  = '{4'b0010, 32'h00005500, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[4]  = '{4'b0000, 32'h0,        4'hF, 1'b0, 4'h0, 1'b1, 8'h55, 2'd1, 4'h0};
    tv[5]  = '{4'b0010, 32'h00006600, 4'hF, 1'b0, 4'h0, 1'b1, 8'h55, 2'd1, 4'h2};
    tv[6]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h2};
    tv[7]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h2};
    tv[8]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h2, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[9]  = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[10] = '{4'b0010, 32'h00007700, 4'hD, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[11] = '{4'b0000, 32'h0,        4'hD, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[12] = '{4'b0010, 32'h00007800, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    tv[13] = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b1, 8'h78, 2'd1, 4'h0};
    tv[14] = '{4'b0000, 32'h0,        4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 4'h0};
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_byte", 32'(out_byte), 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_ovr", 32'(ovr_flags), 0);
    for (int i = 0; i < 15; i++) begin
      rx_done = tv[i].done;
      rx_byte = tv[i].bytes;
      chan_en = tv[i].en;
      out_ready = tv[i].rdy;
      ovr_clr = tv[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_flags), 32'(tv[i].eo));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_byte", i), 32'(out_byte), 32'(tv[i].eb));
        chk($sformatf("vec%0d_chan", i), 32'(out_chan), 32'(tv[i].ec));
      end
    end
    do_reset();
    out_ready = 1'b1;
    send(4'b1111, 32'h13121110);
    expect_pres("burst_c0", 0, 8'h10, n);
    chk("burst_latency", 32'(n), 1);
    for (int c = 1; c < 4; c++) begin
      step();
      expect_pres($sformatf("burst_c%0d", c), c, 8'(8'h10 + c), n);
      chk($sformatf("burst_gap%0d", c), 32'(n + 1), 2);
    end
    step();
    send(4'b1001, 32'h23000020);
    expect_pres("wrap_c0", 0, 8'h20, n);
    step();
    expect_pres("wrap_c3", 3, 8'h23, n);
    step();
    do_reset();
    send(4'b0001, 32'h00000001);
    expect_pres("coll_first", 0, 8'h01, n);
    rx_done = 4'b0001;
    rx_byte = 32'h00000002;
    out_ready = 1'b1;
    step();
    rx_done = '0;
    chk("coll_gap_valid", 32'(out_valid), 0);
    expect_pres("coll_second", 0, 8'h02, n);
    chk("coll_ovr", 32'(ovr_flags), 0);
    step();
    do_reset();
    send(4'b0111, 32'h00333231);
    expect_pres("rst_mid", 0, 8'h31, n);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_async_valid", 32'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_mid_stale%0d", i), 32'(out_valid), 0);
    end
    out_ready = 1'b1;
    send(4'b1000, 32'h3C000000);
    expect_pres("rst_mid_new", 3, 8'h3C, n);
    step();
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      m_held[i] = 1'b0;
      m_val[i] = '0;
    end
    m_ovr = '0;
    m_ptr = 0;
    m_pres = -1;
    m_pbyte = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit xfer;
      int np;
      logic [3:0] ovr_n;
      rx_done = 4'($urandom) & 4'($urandom);
      rx_byte = $urandom;
      chan_en = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      ovr_clr = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      xfer = m_pres >= 0 && out_ready;
      np = m_pres;
      if (m_pres >= 0) begin
        if (xfer) begin
          m_ptr = (m_pres + 1) % NCH;
          np = -1;
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr + k) % NCH;
          if (np < 0 && m_held[c]) begin
            np = c;
            m_pbyte = m_val[c];
          end
        end
      end
      ovr_n = m_ovr & ~ovr_clr;
      for (int i = 0; i < NCH; i++) begin
        if (rx_done[i] && chan_en[i]) begin
          if (!m_held[i] || (xfer && m_pres == i)) begin
            m_val[i] = rx_byte[8*i +: 8];
            m_held[i] = 1'b1;
          end else ovr_n[i] = 1'b1;
        end else if (xfer && m_pres == i) m_held[i] = 1'b0;
      end
      m_ovr = ovr_n;
      m_pres = np;
      step();
      chk("rnd_valid", 32'(out_valid), 32'(m_pres >= 0));
      chk("rnd_ovr", 32'(ovr_flags), 32'(m_ovr));
      if (m_pres >= 0) begin
        chk("rnd_chan", 32'(out_chan), 32'(m_pres));
        chk("rnd_byte", 32'(out_byte), 32'(m_pbyte));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
